// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Package  : vga_pkg
// Purpose  : 640x480@60 timing constants, sync polarity and RGB444 pixel type
// Revision : 1.0
// ============================================================================
package vga_pkg;

    localparam int c_H_ACTIVE = 640;
    localparam int c_H_FP     = 16;
    localparam int c_H_SYNC   = 96;
    localparam int c_H_BP     = 48;
    localparam int c_H_TOTAL  = c_H_ACTIVE + c_H_FP + c_H_SYNC + c_H_BP;

    localparam int c_V_ACTIVE = 480;
    localparam int c_V_FP     = 10;
    localparam int c_V_SYNC   = 2;
    localparam int c_V_BP     = 33;
    localparam int c_V_TOTAL  = c_V_ACTIVE + c_V_FP + c_V_SYNC + c_V_BP;

    localparam int c_CLK_DIV  = 4;
    localparam int c_FB_W     = 320;
    localparam int c_ADDR_W   = 17;

    // Both syncs are active low in this mode
    localparam logic c_HS_ACTIVE = 1'b0;
    localparam logic c_VS_ACTIVE = 1'b0;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

endpackage
`default_nettype wire

// File: rtl/vga_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
// Interface : vga_scan_ctrl_if
// Purpose   : video RAM read port between the scan controller and the RAM
// Revision  : 1.0
// ============================================================================
interface vga_scan_ctrl_if
    import vga_pkg::*;
#(
    parameter int ADDR_W = c_ADDR_W
);
    logic [ADDR_W-1:0] vram_addr;
    logic [11:0]       vram_rd_data;

    modport master (output vram_addr, input  vram_rd_data);
    modport slave  (input  vram_addr, output vram_rd_data);
endinterface
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Purpose  : pixel-tick divider, h/v raster counters, sync/active decode
// Revision : 1.0
// ============================================================================
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = c_H_ACTIVE,
    parameter int H_FP     = c_H_FP,
    parameter int H_SYNC   = c_H_SYNC,
    parameter int H_BP     = c_H_BP,
    parameter int V_ACTIVE = c_V_ACTIVE,
    parameter int V_FP     = c_V_FP,
    parameter int V_SYNC   = c_V_SYNC,
    parameter int V_BP     = c_V_BP,
    parameter int CLK_DIV  = c_CLK_DIV,
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int HW      = $clog2(H_TOTAL),
    localparam int VW      = $clog2(V_TOTAL)
) (
    input  wire logic          clk,
    input  wire logic          reset_n,
    output logic               o_pix_tick,
    output logic               o_active,
    output logic               o_hs_raw,
    output logic               o_vs_raw,
    output logic               o_frame_start,
    output logic [HW-1:0]      o_h_cnt,
    output logic [VW-1:0]      o_v_cnt
);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] c_DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [HW-1:0] c_H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] c_V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0] c_H_ACT    = HW'(H_ACTIVE);
    localparam logic [VW-1:0] c_V_ACT    = VW'(V_ACTIVE);
    localparam logic [HW-1:0] c_HS_BEG   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] c_HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] c_VS_BEG   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] c_VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

    logic [DW-1:0] r_div_cnt;
    logic [HW-1:0] r_h_cnt;
    logic [VW-1:0] r_v_cnt;
    logic          w_pix_tick;
    logic          w_hs_pulse;
    logic          w_vs_pulse;

    assign w_pix_tick = (r_div_cnt == c_DIV_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_div_cnt <= '0;
            r_h_cnt   <= '0;
            r_v_cnt   <= '0;
        end else begin
            r_div_cnt <= w_pix_tick ? '0 : r_div_cnt + 1'b1;
            if (w_pix_tick) begin
                // Line and frame wrap can land on the same tick
                if (r_h_cnt == c_H_LAST) begin
                    r_h_cnt <= '0;
                    r_v_cnt <= (r_v_cnt == c_V_LAST) ? '0 : r_v_cnt + 1'b1;
                end else begin
                    r_h_cnt <= r_h_cnt + 1'b1;
                end
            end
        end
    end

    assign w_hs_pulse    = (r_h_cnt >= c_HS_BEG) && (r_h_cnt < c_HS_END);
    assign w_vs_pulse    = (r_v_cnt >= c_VS_BEG) && (r_v_cnt < c_VS_END);

    assign o_pix_tick    = w_pix_tick;
    assign o_active      = (r_h_cnt < c_H_ACT) && (r_v_cnt < c_V_ACT);
    assign o_hs_raw      = w_hs_pulse ? c_HS_ACTIVE : ~c_HS_ACTIVE;
    assign o_vs_raw      = w_vs_pulse ? c_VS_ACTIVE : ~c_VS_ACTIVE;
    assign o_frame_start = w_pix_tick && (r_h_cnt == '0) && (r_v_cnt == '0);
    assign o_h_cnt       = r_h_cnt;
    assign o_v_cnt       = r_v_cnt;

endmodule
`default_nettype wire

// File: rtl/vga_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : vga_scan_ctrl
// Purpose  : VGA raster scan of a 2x2-doubled 320x240 RGB444 framebuffer
// Revision : 1.0
// ============================================================================
module vga_scan_ctrl
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = c_H_ACTIVE,
    parameter int H_FP     = c_H_FP,
    parameter int H_SYNC   = c_H_SYNC,
    parameter int H_BP     = c_H_BP,
    parameter int V_ACTIVE = c_V_ACTIVE,
    parameter int V_FP     = c_V_FP,
    parameter int V_SYNC   = c_V_SYNC,
    parameter int V_BP     = c_V_BP,
    parameter int CLK_DIV  = c_CLK_DIV,
    parameter int FB_W     = c_FB_W,
    parameter int ADDR_W   = c_ADDR_W
) (
    input  wire logic             clk,
    input  wire logic             reset_n,
    input  wire logic             disp_en,
    vga_scan_ctrl_if.master       vram,
    output logic                  frame_start,
    output logic [3:0]            oRed,
    output logic [3:0]            oGreen,
    output logic [3:0]            oBlue,
    output logic                  oHs,
    output logic                  oVs
);
    localparam int HW = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam int VW = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP);

    logic              w_pix_tick;
    logic              w_active;
    logic              w_hs_raw;
    logic              w_vs_raw;
    logic [HW-1:0]     w_h_cnt;
    logic [VW-1:0]     w_v_cnt;
    logic [ADDR_W-1:0] w_row;
    logic [ADDR_W-1:0] w_col;
    logic [ADDR_W-1:0] w_addr;

    logic [ADDR_W-1:0] r_vram_addr;
    logic              r_active_d;
    logic              r_hs_d;
    logic              r_vs_d;
    rgb444_t           r_pix;
    logic              r_hs;
    logic              r_vs;

    vga_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .CLK_DIV  (CLK_DIV)
    ) u_timing (
        .clk           (clk),
        .reset_n       (reset_n),
        .o_pix_tick    (w_pix_tick),
        .o_active      (w_active),
        .o_hs_raw      (w_hs_raw),
        .o_vs_raw      (w_vs_raw),
        .o_frame_start (frame_start),
        .o_h_cnt       (w_h_cnt),
        .o_v_cnt       (w_v_cnt)
    );

    // Each stored pixel covers 2x2 screen pixels, so drop the LSB of both counters
    assign w_row = ADDR_W'(w_v_cnt >> 1);
    assign w_col = ADDR_W'(w_h_cnt >> 1);

    if (FB_W == 320) begin : g_fb_shift_add
        assign w_addr = (w_row << 8) + (w_row << 6) + w_col;
    end else begin : g_fb_mul
        assign w_addr = ADDR_W'(w_row * ADDR_W'(FB_W)) + w_col;
    end

    // RAM data for the address issued on one tick is consumed on the next tick,
    // so sync and active are delayed by the same single tick to stay aligned.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_vram_addr <= '0;
            r_active_d  <= 1'b0;
            r_hs_d      <= ~c_HS_ACTIVE;
            r_vs_d      <= ~c_VS_ACTIVE;
            r_pix       <= '0;
            r_hs        <= ~c_HS_ACTIVE;
            r_vs        <= ~c_VS_ACTIVE;
        end else if (w_pix_tick) begin
            if (w_active) begin
                r_vram_addr <= w_addr;
            end
            r_active_d <= w_active;
            r_hs_d     <= w_hs_raw;
            r_vs_d     <= w_vs_raw;
            r_pix      <= (r_active_d && disp_en) ? rgb444_t'(vram.vram_rd_data) : '0;
            r_hs       <= r_hs_d;
            r_vs       <= r_vs_d;
        end
    end

    assign vram.vram_addr = r_vram_addr;
    assign oRed           = r_pix.r;
    assign oGreen         = r_pix.g;
    assign oBlue          = r_pix.b;
    assign oHs            = r_hs;
    assign oVs            = r_vs;

endmodule
`default_nettype wire

// File: tb/tb_vga_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_scan_ctrl
// Purpose  : scoreboard bench for vga_scan_ctrl, full-width lines, short frame
// Revision : 1.0
// ============================================================================
module tb_vga_scan_ctrl;

    // Full horizontal timing; vertical shortened so whole frames fit in the run
    localparam int H_TOT  = 800;
    localparam int V_ACT  = 4;
    localparam int V_FPO  = 1;
    localparam int V_SYN  = 2;
    localparam int V_BPO  = 1;
    localparam int V_TOT  = V_ACT + V_FPO + V_SYN + V_BPO;
    localparam int DIV    = 4;
    localparam int FRAME  = H_TOT * V_TOT;

    typedef struct packed {
        int          n;
        logic [16:0] addr;
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;
    logic disp_en;
    logic frame_start;
    logic [3:0] oRed, oGreen, oBlue;
    logic oHs, oVs;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int cnt    = 0;
    logic [16:0] m_last_addr = '0;
    exp_t sb_q[$];

    int hs_last_fall = -1, vs_last_fall = -1, fs_last = -1, hs_ref = 0;
    int hs_falls = 0, vs_falls = 0, fs_count = 0;
    bit first_fall_pending = 0, saw_fs = 0;
    logic prev_hs = 1'b1, prev_vs = 1'b1;

    vga_scan_ctrl_if #(.ADDR_W(17)) vram_bus ();

    vga_scan_ctrl #(
        .V_ACTIVE (V_ACT),
        .V_FP     (V_FPO),
        .V_SYNC   (V_SYN),
        .V_BP     (V_BPO)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .disp_en     (disp_en),
        .vram        (vram_bus),
        .frame_start (frame_start),
        .oRed        (oRed),
        .oGreen      (oGreen),
        .oBlue       (oBlue),
        .oHs         (oHs),
        .oVs         (oVs)
    );

    initial forever #5 clk = ~clk;

    // Video RAM whose word at address a holds a[11:0]
    always @(posedge clk) vram_bus.vram_rd_data <= vram_bus.vram_addr[11:0];

    function automatic bit m_active(input int n);
        int h = n % H_TOT;
        int v = (n / H_TOT) % V_TOT;
        return (h < 640) && (v < V_ACT);
    endfunction

    function automatic logic [16:0] m_addr(input int n);
        int h = n % H_TOT;
        int v = (n / H_TOT) % V_TOT;
        return 17'((v / 2) * 320 + h / 2);
    endfunction

    function automatic logic m_hs(input int n);
        int h = n % H_TOT;
        return !((h >= 656) && (h < 752));
    endfunction

    function automatic logic m_vs(input int n);
        int v = (n / H_TOT) % V_TOT;
        return !((v >= V_ACT + V_FPO) && (v < V_ACT + V_FPO + V_SYN));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Expected pins after tick n reflect raster position n-1
    initial begin : generator
        exp_t        e;
        int          n;
        logic [16:0] a_prev;
        forever begin
            @(posedge clk);
            cyc++;
            if (!reset_n) begin
                cnt         = 0;
                m_last_addr = '0;
            end else begin
                cnt++;
                if (cnt % DIV == 0) begin
                    n = cnt / DIV - 1;
                    if (m_active(n)) m_last_addr = m_addr(n);
                    e.n    = n;
                    e.addr = m_last_addr;
                    if (n == 0) begin
                        e.rgb = 12'h000;
                        e.hs  = 1'b1;
                        e.vs  = 1'b1;
                    end else begin
                        a_prev = m_addr(n - 1);
                        e.rgb  = (m_active(n - 1) && disp_en) ? a_prev[11:0] : 12'h000;
                        e.hs   = m_hs(n - 1);
                        e.vs   = m_vs(n - 1);
                    end
                    sb_q.push_back(e);
                end
            end
        end
    end

    initial begin : monitor
        exp_t e;
        int   nxt;
        logic exp_fs;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                sb_q.delete();
                chk("rst_addr", 32'(vram_bus.vram_addr), 32'd0);
                chk("rst_rgb", 32'({oRed, oGreen, oBlue}), 32'd0);
                chk("rst_hs", 32'(oHs), 32'd1);
                chk("rst_vs", 32'(oVs), 32'd1);
                chk("rst_fs", 32'(frame_start), 32'd0);
                hs_last_fall = -1; vs_last_fall = -1; fs_last = -1;
                first_fall_pending = 0; saw_fs = 0;
                prev_hs = 1'b1; prev_vs = 1'b1;
            end else begin
                nxt    = (cnt + 1) / DIV - 1;
                exp_fs = (cnt % DIV == DIV - 1) && (nxt % FRAME == 0);
                chk("frame_start", 32'(frame_start), 32'(exp_fs));
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    chk($sformatf("addr@tick%0d", e.n), 32'(vram_bus.vram_addr), 32'(e.addr));
                    chk($sformatf("rgb@tick%0d", e.n), 32'({oRed, oGreen, oBlue}), 32'(e.rgb));
                    chk($sformatf("hs@tick%0d", e.n), 32'(oHs), 32'(e.hs));
                    chk($sformatf("vs@tick%0d", e.n), 32'(oVs), 32'(e.vs));
                end
                if (frame_start) begin
                    fs_count++;
                    if (fs_last >= 0) chk("fs_period_clks", 32'(cyc - fs_last), 32'(FRAME * DIV));
                    if (!saw_fs) chk("fs_clks_after_release", 32'(cnt), 32'(DIV - 1));
                    saw_fs = 1;
                    fs_last = cyc;
                    hs_ref  = cyc + 1;   // the tick edge that frame_start marks
                    first_fall_pending = 1;
                end
                if (prev_hs && !oHs) begin
                    hs_falls++;
                    if (hs_last_fall >= 0) chk("hs_period_clks", 32'(cyc - hs_last_fall), 32'(H_TOT * DIV));
                    if (first_fall_pending) chk("hs_first_fall_clks", 32'(cyc - hs_ref), 32'd2628);
                    first_fall_pending = 0;
                    hs_last_fall = cyc;
                end
                if (!prev_hs && oHs && hs_last_fall >= 0)
                    chk("hs_low_clks", 32'(cyc - hs_last_fall), 32'd384);
                if (prev_vs && !oVs) begin
                    vs_falls++;
                    if (vs_last_fall >= 0) chk("vs_period_clks", 32'(cyc - vs_last_fall), 32'(FRAME * DIV));
                    vs_last_fall = cyc;
                end
                if (!prev_vs && oVs && vs_last_fall >= 0)
                    chk("vs_low_clks", 32'(cyc - vs_last_fall), 32'(V_SYN * H_TOT * DIV));
                prev_hs = oHs;
                prev_vs = oVs;
            end
        end
    end

    initial begin : stimulus
        reset_n = 1'b0;
        disp_en = 1'b1;
        #17 reset_n = 1'b1;
        repeat (6400) @(negedge clk);
        repeat (50000) begin
            @(negedge clk);
            if ($urandom_range(0, 255) == 0) disp_en = ~disp_en;
        end
        // Mid-frame reset during an active line; outputs must clear without a clock
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_addr", 32'(vram_bus.vram_addr), 32'd0);
        chk("async_rst_rgb", 32'({oRed, oGreen, oBlue}), 32'd0);
        chk("async_rst_hs", 32'(oHs), 32'd1);
        chk("async_rst_vs", 32'(oVs), 32'd1);
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;
        disp_en = 1'b1;
        repeat (4000) @(negedge clk);
        chk("hs_fall_count_ge_10", 32'(hs_falls >= 10), 32'd1);
        chk("vs_fall_count", 32'(vs_falls), 32'd2);
        chk("fs_count", 32'(fs_count), 32'd4);
        chk("fs_seen_after_mid_reset", 32'(saw_fs), 32'd1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vga_scan_ctrl.md
Name: vga_scan_ctrl

Overview:
- VGA 640x480@60 raster generator inside openmips_min_sopc; drives the top-level oRed/oGreen/oBlue/oHs/oVs pins.
- Derives a pixel tick from the 100 MHz system clock and scans a 320x240, 12-bit-per-pixel video RAM, doubling each stored pixel 2x2.
- Issues read addresses to the video RAM (1-cycle synchronous read) and registers pixel data onto the pins.
- Provides a frame-start pulse and a display-enable gate for the CPU side.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- CLK_DIV, 4, system clocks per pixel
- FB_W, 320, framebuffer width in words
- ADDR_W, 17, video RAM address width

Ports:
- clk  in  1  system clock, 100 MHz
- reset_n  in  1  asynchronous active-low reset
- disp_en  in  1  CPU display enable; when low, RGB outputs are forced black and timing continues
- vram_addr  out  ADDR_W  video RAM read address, registered
- vram_rd_data  in  12  RAM data {R[3:0],G[3:0],B[3:0]}, valid 1 clk after vram_addr
- frame_start  out  1  one-clk pulse at (h=0, v=0) pixel tick
- oRed  out  4  red
- oGreen  out  4  green
- oBlue  out  4  blue
- oHs  out  1  hsync, active low
- oVs  out  1  vsync, active low

Behaviour:
- Reset values:
  - div_cnt=0, h_cnt=0, v_cnt=0, vram_addr=0, frame_start=0.
  - oRed/oGreen/oBlue=0; oHs=1, oVs=1 (inactive).
- Pixel tick:
  - div_cnt counts 0..CLK_DIV-1 and wraps.
  - pix_tick asserts when div_cnt==CLK_DIV-1, so the first tick occurs CLK_DIV clocks after reset release.
- Counters, advancing on pix_tick only:
  - h_cnt runs 0..H_TOTAL-1, where H_TOTAL=800.
  - On h wrap, v_cnt advances through 0..V_TOTAL-1, where V_TOTAL=525, and wraps.
- Timing regions (positions evaluated from the current counters):
  - active = (h_cnt<H_ACTIVE) && (v_cnt<V_ACTIVE).
  - hs_raw low for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC, i.e. 656..751.
  - vs_raw low for lines 490..491.
- Address:
  - On pix_tick, vram_addr <= (v_cnt>>1)*FB_W + (h_cnt>>1) when active; hold the previous value otherwise.
  - Implement the multiply as (y<<8)+(y<<6).
  - Maximum address is 76799.
- Output pipeline, with a fixed latency of 1 pixel tick from counter position to pins:
  - Delay the active flag, hs_raw and vs_raw by one pixel tick.
  - On pix_tick: {oRed,oGreen,oBlue} <= (active_d && disp_en) ? vram_rd_data : 0; oHs <= hs_d; oVs <= vs_d.
  - RAM data is stable because the address changed CLK_DIV-1 >= 1 clocks earlier.
  - All pin outputs change only on pix_tick clock edges.
- frame_start:
  - High for exactly one clk, on the clk where pix_tick fires with h_cnt==0 and v_cnt==0.
  - In a mid-frame reset case, the first frame_start occurs one tick after reset release, at counters (0,0).
- disp_en:
  - Sampled on each pix_tick; takes effect on the next pin update.
  - Never affects sync, counters or addressing.
- Reset mid-operation: asynchronous return to the reset values above. No partial line is emitted; the raster restarts at (0,0).
- Boundary conditions:
  - h wrap and v wrap on the same tick increment/wrap both counters together.
  - Blanking always forces RGB to 0 regardless of vram_rd_data.

Decomposition:
- Package vga_pkg:
  - 640x480 timing localparams, with H_TOTAL/V_TOTAL derived.
  - Sync polarity constants.
  - RGB444 pixel typedef.
- Sub-module vga_timing_gen holds div_cnt, the h/v counters, pix_tick, active, hs_raw, vs_raw and frame_start.
- The top keeps address generation and the output pipeline.

Test Plan:
- Reset/tick:
  - Stimulus: hold reset_n=0 for 17 ns, then release.
  - Required: oHs=oVs=1 and RGB=0 during reset; first pix_tick 4 clks after release.
- Hsync timing:
  - Required: oHs falling-edge period 3200 clks; low width 384 clks.
  - Required: first falling edge at pixel 657 after (0,0), i.e. 2628 clks.
- Vsync timing:
  - Required: oVs period 525*3200 = 1,680,000 clks; low width 6400 clks.
  - Required: frame_start period 1,680,000 clks.
- Address scan:
  - Required: vram_addr = 0,0,1,1,... along line 0; line 1 repeats line 0.
  - Required: line 2 starts at 320; last active pixel gives 76799.
- RGB path:
  - Stimulus: RAM model returns data=addr[11:0].
  - Required: pixel (2,0) emits 12'h001 one tick later.
  - Required: pixel 640 onward emits 0.
- disp_en / mid-frame reset:
  - Stimulus: disp_en=0 mid-frame.
  - Required: RGB 0 from the next tick while oHs/oVs are unchanged.
  - Stimulus: pulse reset_n low at line 100.
  - Required: all outputs at reset values; frame_start one tick after release.
